uart_mmio: RTL and testbench

- Memory-mapped serial port controller on the MEM-stage side of the 16-bit pipelined CPU.
- Decodes CPU accesses to the UART data and status addresses.
- Buffers outgoing bytes in a small TX FIFO and runs the rdn/wrn/data_ready/tbre/tsre strobe protocol toward the external UART chip on the shared Ram1 low data byte.
- Raises a stall request to the hazard unit while a CPU access cannot complete.

---
 rtl/uart_mmio.sv | 163 ++++++++++++++++
 tb/tb_uart_mmio.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// Memory-mapped UART controller: decodes CPU data/status accesses, queues stores in a TX FIFO
// and drives the rdn/wrn strobe handshake toward the external UART chip on Ram1Data[7:0].
module uart_mmio #(
  parameter logic [15:0] ADDR_DATA  = 16'hBF00,
  parameter logic [15:0] ADDR_STAT  = 16'hBF01,
  parameter int          FIFO_DEPTH = 4,
  parameter int          STROBE_CYC = 2,
  parameter int          SETUP_CYC  = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic        isread_i,
  input  logic        iswrite_i,
  output logic [15:0] rdata_o,
  output logic        busy_o,
  input  logic        data_ready_i,
  input  logic        tbre_i,
  input  logic        tsre_i,
  output logic        rdn_o,
  output logic        wrn_o,
  output logic [7:0]  bus_o,
  output logic        bus_oe_o,
  input  logic [7:0]  bus_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 8;

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_STROBE, RD_DONE, WR_SETUP, WR_STROBE, WR_TBRE, WR_TSRE
  } state_t;

  state_t        state_q;
  logic [AW:0]   wrPtr_q, wrPtr_d;
  logic [AW:0]   rdPtr_q, rdPtr_d;
  logic [7:0]    fifoMem_q [FIFO_DEPTH];
  logic [7:0]    rxLatch_q;
  logic [7:0]    bus_q;
  logic          rdn_q, wrn_q, busOe_q;
  logic [CW-1:0] cnt_q;

  logic hitData, hitStat, readPending;
  logic fifoEmpty, fifoFull, push, pop;
  logic unusedWdata;

  assign hitData     = req_i && (addr_i == ADDR_DATA);
  assign hitStat     = req_i && (addr_i == ADDR_STAT);
  assign readPending = hitData && isread_i;
  assign unusedWdata = ^wdata_i[15:8];

  // The extra pointer MSB distinguishes a full FIFO from an empty one.
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  assign pop  = (state_q == IDLE) && !readPending && !fifoEmpty;
  assign push = hitData && iswrite_i && (!fifoFull || pop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push) wrPtr_d = wrPtr_q + {{AW{1'b0}}, 1'b1};
    if (pop)  rdPtr_d = rdPtr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset; the pointers alone define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) fifoMem_q[wrPtr_q[AW-1:0]] <= wdata_i[7:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      rdn_q     <= 1'b1;
      wrn_q     <= 1'b1;
      busOe_q   <= 1'b0;
      bus_q     <= '0;
      rxLatch_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (readPending) begin
            state_q <= RD_WAIT;
          end else if (pop) begin
            bus_q   <= fifoMem_q[rdPtr_q[AW-1:0]];
            busOe_q <= 1'b1;
            cnt_q   <= CW'(SETUP_CYC - 1);
            state_q <= WR_SETUP;
          end
        end
        RD_WAIT: begin
          busOe_q <= 1'b0;
          if (data_ready_i) begin
            rdn_q   <= 1'b0;
            cnt_q   <= CW'(STROBE_CYC - 1);
            state_q <= RD_STROBE;
          end
        end
        RD_STROBE: begin
          if (cnt_q == '0) begin
            rxLatch_q <= bus_i;
            rdn_q     <= 1'b1;
            state_q   <= RD_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RD_DONE: state_q <= IDLE;
        WR_SETUP: begin
          if (cnt_q == '0) begin
            wrn_q   <= 1'b0;
            cnt_q   <= CW'(STROBE_CYC - 1);
            state_q <= WR_STROBE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        WR_STROBE: begin
          if (cnt_q == '0) begin
            wrn_q   <= 1'b1;
            busOe_q <= 1'b0;
            state_q <= WR_TBRE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        WR_TBRE: if (tbre_i) state_q <= WR_TSRE;
        WR_TSRE: if (tsre_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdn_o    = rdn_q;
  assign wrn_o    = wrn_q;
  assign bus_o    = bus_q;
  assign bus_oe_o = busOe_q;

  assign busy_o = (hitData && iswrite_i && fifoFull && !pop) ||
                  (readPending && (state_q != RD_DONE));

  always_comb begin
    rdata_o = '0;
    if (hitStat && isread_i)
      rdata_o = {14'b0, data_ready_i, ~fifoFull};
    else if (readPending && (state_q == RD_DONE))
      rdata_o = {8'b0, rxLatch_q};
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: directed scenarios plus a randomized phase, with a
// transaction-level model (byte queue, strobe widths, access latency) and a UART chip responder.
module tb_uart_mmio;

  localparam logic [15:0] ADDR_DATA = 16'hBF00;
  localparam logic [15:0] ADDR_STAT = 16'hBF01;
  localparam int LIMIT = 500;

  logic        clock, reset;
  logic        req, isRead, isWrite;
  logic [15:0] addrIn, wdataIn, rdataOut;
  logic        busyOut, dataReady, tbre, tsre;
  logic        rdnOut, wrnOut, busOeOut;
  logic [7:0]  busOut, busIn;

  int errorCount = 0;
  int checkCount = 0;

  logic [7:0] expQ[$];
  logic [7:0] txSeen[$];
  bit         autoUart;

  logic [15:0] rd, rd5;
  int          st, st5, w;

  uart_mmio dut (
    .CLK(clock), .RST(reset),
    .req_i(req), .addr_i(addrIn), .wdata_i(wdataIn),
    .isread_i(isRead), .iswrite_i(isWrite),
    .rdata_o(rdataOut), .busy_o(busyOut),
    .data_ready_i(dataReady), .tbre_i(tbre), .tsre_i(tsre),
    .rdn_o(rdnOut), .wrn_o(wrnOut),
    .bus_o(busOut), .bus_oe_o(busOeOut), .bus_i(busIn)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One CPU access, started just after a rising edge; it completes on the first edge
  // with busy low, and the load data is captured on the falling edge before it.
  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data, input bit wr,
                               output logic [15:0] rdv, output int stalls);
    req = 1'b1; addrIn = addr; wdataIn = data; isWrite = wr; isRead = !wr;
    stalls = 0;
    @(negedge clock);
    while (busyOut && stalls < LIMIT) begin
      stalls++;
      @(negedge clock);
    end
    if (stalls >= LIMIT) checkOutput("accessTimeout", stalls < LIMIT, 1);
    rdv = rdataOut;
    @(posedge clock);
    #1;
    req = 1'b0; isWrite = 1'b0; isRead = 1'b0; addrIn = '0; wdataIn = '0;
  endtask

  task automatic drainTx();
    int waited = 0;
    while ((txSeen.size() < expQ.size() || !(wrnOut && !busOeOut && tbre && tsre))
           && waited < 4 * LIMIT) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 4 * LIMIT) checkOutput("drainTimeout", waited < 4 * LIMIT, 1);
    repeat (3) @(negedge clock);
    checkOutput("txCount", txSeen.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < txSeen.size(); i++)
      checkOutput("txByte", txSeen[i], expQ[i]);
    txSeen.delete();
    expQ.delete();
    @(posedge clock);
    #1;
  endtask

  task automatic waitForOe();
    int n = 0;
    while (!busOeOut && n < LIMIT) begin
      @(negedge clock);
      n++;
    end
    if (n >= LIMIT) checkOutput("oeTimeout", n < LIMIT, 1);
    @(posedge clock);
    #1;
  endtask

  // Strobe monitor: records each transmitted byte and checks setup/strobe widths and exclusivity.
  int setupCnt, wrnLowCnt, rdnLowCnt;
  logic prevWrn, prevRdn;
  initial begin
    setupCnt = 0; wrnLowCnt = 0; rdnLowCnt = 0; prevWrn = 1'b1; prevRdn = 1'b1;
    forever begin
      @(negedge clock);
      if (reset) begin
        setupCnt = 0; wrnLowCnt = 0; rdnLowCnt = 0; prevWrn = 1'b1; prevRdn = 1'b1;
      end else begin
        if (busOeOut && wrnOut) setupCnt++;
        if (!wrnOut && prevWrn) begin
          txSeen.push_back(busOut);
          checkOutput("setupCycles", setupCnt, 1);
          checkOutput("oeDuringStrobe", busOeOut, 1);
          setupCnt = 0;
          wrnLowCnt = 0;
        end
        if (!wrnOut) wrnLowCnt++;
        if (wrnOut && !prevWrn) checkOutput("wrnWidth", wrnLowCnt, 2);
        if (!rdnOut && prevRdn) rdnLowCnt = 0;
        if (!rdnOut) begin
          rdnLowCnt++;
          checkOutput("rdnExclusive", {wrnOut, busOeOut}, 2'b10);
        end
        if (rdnOut && !prevRdn) checkOutput("rdnWidth", rdnLowCnt, 2);
        prevWrn = wrnOut;
        prevRdn = rdnOut;
      end
    end
  end

  // External UART chip: after each write strobe the buffers go busy, then drain after a short delay.
  initial begin
    forever begin
      @(negedge wrnOut);
      if (autoUart) begin
        tbre = 1'b0;
        tsre = 1'b0;
        @(posedge wrnOut);
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1 tbre = 1'b1;
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1 tsre = 1'b1;
      end
    end
  end

  initial begin
    reset = 1'b1; req = 1'b0; isRead = 1'b0; isWrite = 1'b0; addrIn = '0; wdataIn = '0;
    dataReady = 1'b0; tbre = 1'b1; tsre = 1'b1; busIn = '0; autoUart = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    checkOutput("rstRdn", rdnOut, 1);
    checkOutput("rstWrn", wrnOut, 1);
    checkOutput("rstOe", busOeOut, 0);
    checkOutput("rstBusy", busyOut, 0);
    checkOutput("rstRdata", rdataOut, 0);
    checkOutput("rstBus", busOut, 0);
    @(posedge clock);
    #1;
    applyStimulus(ADDR_STAT, 16'h0, 1'b0, rd, st);
    checkOutput("statIdle", rd, 16'h0001);
    checkOutput("statNoStall", st, 0);

    // Single store; the FSM must wait on tbre then on tsre before the next byte starts.
    tbre = 1'b0; tsre = 1'b0;
    applyStimulus(ADDR_DATA, 16'h1234, 1'b1, rd, st);
    checkOutput("storeNoStall", st, 0);
    expQ.push_back(8'h34);
    w = 0;
    while (!(txSeen.size() > 0 && wrnOut) && w < LIMIT) begin
      @(negedge clock);
      w++;
    end
    if (w >= LIMIT) checkOutput("firstTxTimeout", w < LIMIT, 1);
    @(posedge clock);
    #1;
    applyStimulus(ADDR_DATA, 16'h0099, 1'b1, rd, st);
    expQ.push_back(8'h99);
    repeat (4) @(negedge clock) checkOutput("holdTbre", busOeOut, 0);
    @(posedge clock);
    #1 tbre = 1'b1;
    repeat (4) @(negedge clock) checkOutput("holdTsre", busOeOut, 0);
    @(posedge clock);
    #1 tsre = 1'b1;
    w = 0;
    while (!busOeOut && w < 8) begin
      @(negedge clock);
      w++;
    end
    checkOutput("resumeAfterTsre", busOeOut, 1);
    @(posedge clock);
    #1;
    drainTx();

    // FIFO full: one byte stuck in the chip handshake, four more fill the FIFO, the fifth stalls.
    tbre = 1'b0; tsre = 1'b0;
    applyStimulus(ADDR_DATA, 16'h0040, 1'b1, rd, st);
    expQ.push_back(8'h40);
    waitForOe();
    for (int b = 8'h41; b <= 8'h44; b++) begin
      applyStimulus(ADDR_DATA, 16'(b), 1'b1, rd, st);
      checkOutput("fillNoStall", st, 0);
      expQ.push_back(8'(b));
    end
    applyStimulus(ADDR_STAT, 16'h0, 1'b0, rd, st);
    checkOutput("statFull", rd, 16'h0000);
    fork
      applyStimulus(ADDR_DATA, 16'h0045, 1'b1, rd5, st5);
      begin
        repeat (3) @(negedge clock) checkOutput("fullBusy", busyOut, 1);
        @(posedge clock);
        #1 tbre = 1'b1;
        repeat (2) @(posedge clock);
        #1 tsre = 1'b1;
      end
    join
    checkOutput("fullStallSeen", st5 >= 3, 1);
    expQ.push_back(8'h45);
    drainTx();

    // Load: stays stalled with rdn high until the chip reports data.
    autoUart = 1'b1;
    dataReady = 1'b0; busIn = 8'hA5;
    fork
      applyStimulus(ADDR_DATA, 16'h0, 1'b0, rd, st);
      begin
        repeat (3) @(negedge clock) begin
          checkOutput("loadBusy", busyOut, 1);
          checkOutput("loadRdnIdle", rdnOut, 1);
        end
        @(posedge clock);
        #1 dataReady = 1'b1;
      end
    join
    checkOutput("loadData", rd, 16'h00A5);
    dataReady = 1'b0;
    @(negedge clock);
    checkOutput("afterLoadBusy", busyOut, 0);
    checkOutput("afterLoadRdata", rdataOut, 0);
    @(posedge clock);
    #1;

    // Load issued while a transmit is under way waits for the whole write handshake.
    dataReady = 1'b1; busIn = 8'h3C;
    applyStimulus(ADDR_DATA, 16'h0055, 1'b1, rd, st);
    expQ.push_back(8'h55);
    waitForOe();
    applyStimulus(ADDR_DATA, 16'h0, 1'b0, rd, st);
    checkOutput("loadDuringTx", rd, 16'h003C);
    checkOutput("loadWaitsTx", st >= 7, 1);
    dataReady = 1'b0;
    drainTx();

    // Randomized mix of stores, loads, foreign addresses and status reads.
    for (int it = 0; it < 40; it++) begin
      int op;
      logic [7:0] b;
      logic [15:0] a;
      op = $urandom_range(0, 3);
      b = 8'($urandom);
      case (op)
        0: begin
          applyStimulus(ADDR_DATA, {8'($urandom), b}, 1'b1, rd, st);
          expQ.push_back(b);
        end
        1: begin
          int d;
          d = $urandom_range(0, 4);
          dataReady = 1'b0;
          fork
            applyStimulus(ADDR_DATA, 16'h0, 1'b0, rd, st);
            begin
              repeat (d) @(posedge clock);
              #1 busIn = b;
              dataReady = 1'b1;
            end
          join
          checkOutput("randLoad", rd, {8'h00, b});
          dataReady = 1'b0;
        end
        2: begin
          a = 16'($urandom);
          if (a == ADDR_DATA || a == ADDR_STAT) a = a ^ 16'h0100;
          applyStimulus(a, 16'($urandom), 1'($urandom), rd, st);
          checkOutput("otherNoStall", st, 0);
          checkOutput("otherRdata", rd, 0);
        end
        default: begin
          drainTx();
          applyStimulus(ADDR_STAT, 16'h0, 1'b0, rd, st);
          checkOutput("randStatus", rd, 16'h0001);
          checkOutput("randStatusNoStall", st, 0);
        end
      endcase
    end
    drainTx();

    // Async reset while the write strobe is low, with further bytes still queued.
    tbre = 1'b1; tsre = 1'b1;
    applyStimulus(ADDR_DATA, 16'h0077, 1'b1, rd, st);
    applyStimulus(ADDR_DATA, 16'h0078, 1'b1, rd, st);
    applyStimulus(ADDR_DATA, 16'h0079, 1'b1, rd, st);
    w = 0;
    while (wrnOut && w < LIMIT) begin
      @(negedge clock);
      w++;
    end
    if (w >= LIMIT) checkOutput("strobeTimeout", w < LIMIT, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncRstWrn", wrnOut, 1);
    checkOutput("asyncRstOe", busOeOut, 0);
    checkOutput("asyncRstRdn", rdnOut, 1);
    txSeen.delete();
    expQ.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    applyStimulus(ADDR_STAT, 16'h0, 1'b0, rd, st);
    checkOutput("statAfterRst", rd, 16'h0001);
    repeat (10) @(negedge clock);
    checkOutput("noTxAfterRst", txSeen.size(), 0);
    checkOutput("wrnIdleAfterRst", wrnOut, 1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
